// File: rtl/wb_serial_master.sv
// Framed byte stream to single 32-bit Wishbone cycles.
// Replies with a status byte, plus read data, on a valid/ready tx stream.
module wb_serial_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WB_TIMEOUT = 255,
  parameter int RX_TIMEOUT = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic [7:0]              o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    o_busy,
  output logic                    o_rx_drop
);

  localparam int WBW = $clog2(WB_TIMEOUT + 1);
  localparam int RXW = $clog2(RX_TIMEOUT + 1);

  localparam logic [7:0] CMD_WR = 8'hA5;
  localparam logic [7:0] CMD_RD = 8'h5A;
  localparam logic [7:0] ST_OK  = 8'h00;
  localparam logic [7:0] ST_ERR = 8'hE1;
  localparam logic [7:0] ST_TO  = 8'hE2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  cyc_q, cyc_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [2:0]            tx_cnt_q, tx_cnt_d;
  logic [WBW-1:0]        wb_cnt_q, wb_cnt_d;
  logic [RXW-1:0]        rx_cnt_q, rx_cnt_d;
  logic                  rx_drop_q, rx_drop_d;

  logic rx_to;
  logic wb_to;
  logic idle_parse;

  assign rx_to = rx_cnt_q == RXW'(RX_TIMEOUT - 1);
  assign wb_to = wb_cnt_q == WBW'(WB_TIMEOUT - 1);

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cyc_d      = cyc_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_cnt_d   = tx_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rx_drop_d  = 1'b0;
    idle_parse = 1'b0;
    unique case (state_q)
      S_IDLE: idle_parse = i_rx_valid;
      S_ADDR, S_DATA: begin
        // a byte landing on the timeout cycle restarts parsing
        if (rx_to) begin
          state_d    = S_IDLE;
          idle_parse = i_rx_valid;
        end else if (i_rx_valid) begin
          rx_cnt_d = '0;
          cnt_d    = cnt_q + 2'd1;
          if (state_q == S_ADDR)
            addr_d = {addr_q[ADDR_WIDTH-9:0], i_rx_data};
          else
            wdata_d = {wdata_q[DATA_WIDTH-9:0], i_rx_data};
          if (cnt_q == 2'd3) begin
            if (state_q == S_ADDR && we_q) begin
              state_d = S_DATA;
            end else begin
              state_d  = S_BUS;
              cyc_d    = 1'b1;
              wb_cnt_d = '0;
            end
          end
        end else begin
          rx_cnt_d = rx_cnt_q + RXW'(1);
        end
      end
      S_BUS: begin
        rx_drop_d = i_rx_valid;
        if (wb_err_i || wb_ack_i || wb_to) begin
          cyc_d      = 1'b0;
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_cnt_d   = '0;
          rdata_d    = '0;
          if (wb_err_i) begin
            tx_data_d = ST_ERR;
          end else if (wb_ack_i) begin
            tx_data_d = ST_OK;
            if (!we_q)
              rdata_d = wb_dat_i;
          end else begin
            tx_data_d = ST_TO;
          end
        end else begin
          wb_cnt_d = wb_cnt_q + WBW'(1);
        end
      end
      S_RESP: begin
        rx_drop_d = i_rx_valid;
        if (tx_valid_q && i_tx_ready) begin
          if (we_q || tx_cnt_q == 3'd4) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = rdata_q[DATA_WIDTH-1 -: 8];
            rdata_d   = rdata_q << 8;
            tx_cnt_d  = tx_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (idle_parse &&
        (i_rx_data == CMD_WR ||
         i_rx_data == CMD_RD)) begin
      we_d     = i_rx_data == CMD_WR;
      state_d  = S_ADDR;
      cnt_d    = '0;
      rx_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cyc_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_cnt_q   <= '0;
      wb_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rx_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cyc_q      <= cyc_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_cnt_q   <= tx_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_drop_q  <= rx_drop_d;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign wb_adr_o   = addr_q;
  assign wb_dat_o   = wdata_q;
  assign wb_we_o    = cyc_q & we_q;
  assign wb_sel_o   = '1;
  assign wb_stb_o   = cyc_q;
  assign wb_cyc_o   = cyc_q;
  assign o_busy     = state_q != S_IDLE;
  assign o_rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_wb_serial_master.sv
// Randomized bench for wb_serial_master with a Wishbone slave model,
// a tx sink and a frame-level reference model.
module tb_wb_serial_master;

  localparam int WBT = 255;
  localparam int RXT = 100;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b1;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        o_busy;
  logic        o_rx_drop;

  always #5 clk = ~clk;

  wb_serial_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .WB_TIMEOUT(WBT),
    .RX_TIMEOUT(RXT)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_rx_data(i_rx_data),
    .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data),
    .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i),
    .o_busy(o_busy),
    .o_rx_drop(o_rx_drop)
  );

  int errors = 0;
  int checks = 0;

  int sl_mode = M_ACK;
  int sl_lat = 1;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit          in_cyc = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          bus_cnt = 0;
  int          stab_err = 0;
  logic [31:0] cap_adr = '0;
  logic [31:0] cap_dat = '0;
  logic        cap_we = 1'b0;
  logic [3:0]  cap_sel = '0;

  bq_t         txq;
  bit          rdy_rand = 0;
  int          stall_left = 0;
  int          drop_cnt = 0;
  int          tx_stab_err = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = '0;

  // slave, bus monitor and tx sink, all acting between clock edges
  always @(negedge clk) begin
    if (o_rx_drop === 1'b1) drop_cnt++;
    if (wb_cyc_o === 1'b1) begin
      if (!in_cyc) begin
        in_cyc  = 1;
        cur_len = 0;
        cap_adr = wb_adr_o;
        cap_dat = wb_dat_o;
        cap_we  = wb_we_o;
        cap_sel = wb_sel_o;
      end else if (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat ||
                   wb_we_o !== cap_we || wb_sel_o !== cap_sel) begin
        stab_err++;
      end
      if (wb_stb_o !== 1'b1) stab_err++;
      cur_len++;
      wb_ack_i = (sl_mode == M_ACK || sl_mode == M_BOTH) && cur_len == sl_lat;
      wb_err_i = (sl_mode == M_ERR || sl_mode == M_BOTH) && cur_len == sl_lat;
      if (wb_ack_i)
        wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : ~wb_adr_o;
      else
        wb_dat_i = $urandom;
      if (wb_ack_i && !wb_err_i && wb_we_o)
        mem[wb_adr_o] = wb_dat_o;
    end else begin
      if (wb_stb_o === 1'b1) stab_err++;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (in_cyc) begin
        in_cyc   = 0;
        bus_cnt++;
        last_len = cur_len;
      end
    end
    if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data))
      tx_stab_err++;
    if (stall_left > 0 && o_tx_valid === 1'b1) begin
      i_tx_ready = 1'b0;
      stall_left--;
    end else if (rdy_rand) begin
      i_tx_ready = 1'($urandom_range(0, 1));
    end else begin
      i_tx_ready = 1'b1;
    end
    if (o_tx_valid === 1'b1 && i_tx_ready) txq.push_back(o_tx_data);
    prev_stall = o_tx_valid === 1'b1 && !i_tx_ready;
    prev_data  = o_tx_data;
  end

  function automatic string fmt(input bq_t q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic bit q_eq(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 0;
    foreach (a[i]) if (a[i] !== b[i]) return 0;
    return 1;
  endfunction

  function automatic bq_t frame(input bit we, input logic [31:0] a,
                                input logic [31:0] d);
    bq_t q;
    q.push_back(we ? 8'hA5 : 8'h5A);
    for (int i = 3; i >= 0; i--) q.push_back(a[i*8 +: 8]);
    if (we) for (int i = 3; i >= 0; i--) q.push_back(d[i*8 +: 8]);
    return q;
  endfunction

  // expected reply of one complete frame, from the frame rules alone
  task automatic model_frame(input bit we, input logic [31:0] a,
                             input logic [31:0] d, input int mode,
                             output bq_t exp);
    logic [7:0]  st;
    logic [31:0] rd;
    rd = '0;
    if (mode == M_ACK) begin
      st = 8'h00;
      if (we) ref_mem[a] = d;
      else rd = ref_mem.exists(a) ? ref_mem[a] : ~a;
    end else if (mode == M_NONE) begin
      st = 8'hE2;
    end else begin
      st = 8'hE1;
    end
    exp = {};
    exp.push_back(st);
    if (!we) for (int i = 3; i >= 0; i--) exp.push_back(rd[i*8 +: 8]);
  endtask

  task automatic send_bytes(input bq_t bs, input int gmax);
    foreach (bs[i]) begin
      @(negedge clk);
      i_rx_data  = bs[i];
      i_rx_valid = 1'b1;
      repeat ($urandom_range(0, gmax)) begin
        @(negedge clk);
        i_rx_valid = 1'b0;
      end
    end
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy !== 1'b0 && n < 5000);
    to = o_busy !== 1'b0;
  endtask

  task automatic wait_tx_valid(output bit to);
    int n = 0;
    while (o_tx_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    to = o_tx_valid !== 1'b1;
  endtask

  task automatic run_frame(input bit we, input logic [31:0] a,
                           input logic [31:0] d, input int mode,
                           input int lat, input int gmax, output bit to);
    sl_mode = mode;
    sl_lat  = lat;
    txq.delete();
    send_bytes(frame(we, a, d), gmax);
    wait_idle(to);
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, o_busy, o_rx_drop} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {o_tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, o_busy, o_rx_drop});
    end
    checks++;
    if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got adr=%h dat=%h want 0", wb_adr_o, wb_dat_o);
    end
    checks++;
    if (o_tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_txdata got %h want 00", o_tx_data);
    end
    checks++;
    if (wb_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_sel got %h want f", wb_sel_o);
    end
    i_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_led;
    bit  to;
    bq_t exp;
    int  b0 = bus_cnt;
    run_frame(1'b1, 32'h0, 32'h2A, M_ACK, 3, 0, to);
    ref_mem[32'h0] = 32'h2A;
    exp = {8'h00};
    checks++;
    if (to || !q_eq(txq, exp)) begin
      errors++;
      $display("FAIL write_tx got %s want %s", fmt(txq), fmt(exp));
    end
    checks++;
    if (bus_cnt != b0 + 1 || last_len != 3) begin
      errors++;
      $display("FAIL write_cyc got n=%0d len=%0d want n=1 len=3",
               bus_cnt - b0, last_len);
    end
    checks++;
    if (cap_we !== 1'b1 || cap_adr !== 32'h0 ||
        cap_dat !== 32'h2A || cap_sel !== 4'hF) begin
      errors++;
      $display("FAIL write_bus got we=%b adr=%h dat=%h sel=%h want 1 0 2a f",
               cap_we, cap_adr, cap_dat, cap_sel);
    end
    checks++;
    if (!mem.exists(32'h0) || mem[32'h0] !== 32'h2A) begin
      errors++;
      $display("FAIL write_led got %h want 0000002a", mem[32'h0]);
    end
  endtask

  task automatic test_read_led;
    bit  to;
    bq_t exp;
    run_frame(1'b0, 32'h0, 32'h0, M_ACK, 2, 0, to);
    exp = {8'h00, 8'h00, 8'h00, 8'h00, 8'h2A};
    checks++;
    if (to || !q_eq(txq, exp)) begin
      errors++;
      $display("FAIL read_tx got %s want %s", fmt(txq), fmt(exp));
    end
    checks++;
    if (cap_we !== 1'b0 || cap_adr !== 32'h0 || last_len != 2) begin
      errors++;
      $display("FAIL read_bus got we=%b adr=%h len=%0d want 0 0 2",
               cap_we, cap_adr, last_len);
    end
  endtask

  task automatic test_random;
    bit          to;
    bit          we;
    bq_t         exp;
    logic [31:0] a;
    logic [31:0] d;
    int          mode;
    int          lat;
    int          b0;
    int          d0 = drop_cnt;
    rdy_rand = 1;
    for (int it = 0; it < 25; it++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) a = $urandom;
      else a = 32'(($urandom_range(0, 7) + 1) * 4);
      d    = $urandom;
      mode = ($urandom_range(0, 3) == 0) ? $urandom_range(M_ERR, M_BOTH) : M_ACK;
      lat  = $urandom_range(1, 6);
      b0   = bus_cnt;
      model_frame(we, a, d, mode, exp);
      run_frame(we, a, d, mode, lat, 3, to);
      checks++;
      if (to || !q_eq(txq, exp)) begin
        errors++;
        $display("FAIL rand%0d_tx got %s want %s", it, fmt(txq), fmt(exp));
      end
      checks++;
      if (bus_cnt != b0 + 1 || last_len != lat) begin
        errors++;
        $display("FAIL rand%0d_cyc got n=%0d len=%0d want n=1 len=%0d",
                 it, bus_cnt - b0, last_len, lat);
      end
      checks++;
      if (cap_we !== we || cap_adr !== a || cap_sel !== 4'hF ||
          (we && cap_dat !== d)) begin
        errors++;
        $display("FAIL rand%0d_bus got we=%b adr=%h dat=%h want %b %h %h",
                 it, cap_we, cap_adr, cap_dat, we, a, d);
      end
    end
    rdy_rand = 0;
    checks++;
    if (stab_err != 0 || tx_stab_err != 0 || drop_cnt != d0) begin
      errors++;
      $display("FAIL rand_stable got bus=%0d tx=%0d drops=%0d want 0 0 0",
               stab_err, tx_stab_err, drop_cnt - d0);
    end
  endtask

  task automatic test_timeout;
    bit  to;
    bq_t exp;
    run_frame(1'b1, 32'h10, 32'h55, M_NONE, 0, 0, to);
    exp = {8'hE2};
    checks++;
    if (to || !q_eq(txq, exp) || last_len != WBT) begin
      errors++;
      $display("FAIL wto got %s len=%0d want %s len=%0d",
               fmt(txq), last_len, fmt(exp), WBT);
    end
    run_frame(1'b0, 32'h0, 32'h0, M_NONE, 0, 0, to);
    exp = {8'hE2, 8'h00, 8'h00, 8'h00, 8'h00};
    checks++;
    if (to || !q_eq(txq, exp) || last_len != WBT) begin
      errors++;
      $display("FAIL rto got %s len=%0d want %s len=%0d",
               fmt(txq), last_len, fmt(exp), WBT);
    end
  endtask

  task automatic test_error;
    bit  to;
    bq_t exp;
    run_frame(1'b1, 32'h4, 32'h1234, M_ERR, 2, 0, to);
    exp = {8'hE1};
    checks++;
    if (to || !q_eq(txq, exp) || last_len != 2) begin
      errors++;
      $display("FAIL err got %s len=%0d want %s len=2",
               fmt(txq), last_len, fmt(exp));
    end
    run_frame(1'b0, 32'h0, 32'h0, M_BOTH, 1, 0, to);
    exp = {8'hE1, 8'h00, 8'h00, 8'h00, 8'h00};
    checks++;
    if (to || !q_eq(txq, exp) || last_len != 1) begin
      errors++;
      $display("FAIL err_ack got %s len=%0d want %s len=1",
               fmt(txq), last_len, fmt(exp));
    end
  endtask

  task automatic test_backpressure;
    bit  to;
    bq_t exp;
    int  bad = 0;
    int  e0 = tx_stab_err;
    sl_mode = M_ACK;
    sl_lat  = 1;
    stall_left = 10;
    txq.delete();
    send_bytes(frame(1'b0, 32'h0, 32'h0), 0);
    wait_tx_valid(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bp_valid got no tx_valid want tx_valid");
    end
    repeat (10) begin
      @(negedge clk);
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0 || txq.size() != 0) begin
      errors++;
      $display("FAIL bp_hold got bad=%0d sent=%0d want 0 0", bad, txq.size());
    end
    wait_idle(to);
    exp = {8'h00, 8'h00, 8'h00, 8'h00, 8'h2A};
    checks++;
    if (to || !q_eq(txq, exp) || tx_stab_err != e0) begin
      errors++;
      $display("FAIL bp_tx got %s want %s", fmt(txq), fmt(exp));
    end
  endtask

  task automatic test_rx_timeout;
    bit          to;
    bq_t         exp;
    logic [31:0] a;
    int          b0 = bus_cnt;
    send_bytes({8'hA5, 8'h00, 8'h00}, 0);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rxto_busy got %b want 1", o_busy);
    end
    repeat (RXT + 5) @(negedge clk);
    checks++;
    if (bus_cnt != b0 || in_cyc || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rxto_abort got cycles=%0d busy=%b want 0 0",
               bus_cnt - b0, o_busy);
    end
    a = 32'(($urandom_range(0, 7) + 1) * 4);
    model_frame(1'b0, a, 32'h0, M_ACK, exp);
    run_frame(1'b0, a, 32'h0, M_ACK, 1, 0, to);
    checks++;
    if (to || !q_eq(txq, exp)) begin
      errors++;
      $display("FAIL rxto_next got %s want %s", fmt(txq), fmt(exp));
    end
    // next command byte lands exactly on the timeout cycle
    send_bytes({8'hA5, 8'h00}, 0);
    repeat (RXT - 2) @(negedge clk);
    b0 = bus_cnt;
    txq.delete();
    model_frame(1'b0, a, 32'h0, M_ACK, exp);
    send_bytes(frame(1'b0, a, 32'h0), 0);
    wait_idle(to);
    checks++;
    if (to || !q_eq(txq, exp) || bus_cnt != b0 + 1 ||
        cap_we !== 1'b0 || cap_adr !== a) begin
      errors++;
      $display("FAIL rxto_same got %s adr=%h we=%b want %s adr=%h we=0",
               fmt(txq), cap_adr, cap_we, fmt(exp), a);
    end
  endtask

  task automatic test_drop;
    bit          to;
    bq_t         exp;
    logic [31:0] a;
    int          d0 = drop_cnt;
    int          b0;
    send_bytes({8'h77}, 0);
    @(negedge clk);
    checks++;
    if (drop_cnt != d0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL junk_idle got drops=%0d busy=%b want 0 0",
               drop_cnt - d0, o_busy);
    end
    a = 32'(($urandom_range(0, 7) + 1) * 4);
    model_frame(1'b0, a, 32'h0, M_ACK, exp);
    sl_mode = M_ACK;
    sl_lat  = 1;
    stall_left = 6;
    txq.delete();
    b0 = bus_cnt;
    send_bytes(frame(1'b0, a, 32'h0), 0);
    wait_tx_valid(to);
    send_bytes({8'h5A}, 0);
    wait_idle(to);
    checks++;
    if (drop_cnt != d0 + 1) begin
      errors++;
      $display("FAIL drop_pulse got %0d want 1", drop_cnt - d0);
    end
    checks++;
    if (to || !q_eq(txq, exp) || bus_cnt != b0 + 1) begin
      errors++;
      $display("FAIL drop_tx got %s cycles=%0d want %s cycles=1",
               fmt(txq), bus_cnt - b0, fmt(exp));
    end
  endtask

  task automatic test_reset_mid_bus;
    bit  to;
    bq_t exp;
    sl_mode = M_NONE;
    send_bytes(frame(1'b1, 32'h20, 32'hCAFE), 0);
    repeat (5) @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got cyc=%b want 1", wb_cyc_o);
    end
    i_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 ||
        o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_bus got cyc=%b stb=%b busy=%b txv=%b want 0 0 0 0",
               wb_cyc_o, wb_stb_o, o_busy, o_tx_valid);
    end
    i_rst = 1'b0;
    @(negedge clk);
    run_frame(1'b0, 32'h0, 32'h0, M_ACK, 1, 0, to);
    exp = {8'h00, 8'h00, 8'h00, 8'h00, 8'h2A};
    checks++;
    if (to || !q_eq(txq, exp)) begin
      errors++;
      $display("FAIL rst_recover got %s want %s", fmt(txq), fmt(exp));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_led();
    test_read_led();
    test_random();
    test_timeout();
    test_error();
    test_backpressure();
    test_rx_timeout();
    test_drop();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
